controle_atuadores: RTL and testbench

CONTROLE_ATUADORES -- requirements
Module: controle_atuadores

---
 rtl/controle_atuadores.sv | 223 ++++++++++++++++++++++
 tb/tb_controle_atuadores.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_atuadores.sv
// -----------------------------------------------------------------------------
// controle_atuadores
//
// Actuator sequencer for an irrigation controller. Turns the request levels
// produced by the decision logic into a safe on/off sequence for the pump,
// the two irrigation valves and the siren:
//
//   OCIOSO -> PARTIDA (pump priming, valves closed)
//          -> GOTEJO or ASPERSAO (pump + exactly one valve, minimum on-time)
//          -> PAUSA (everything off, fixed rest time) -> OCIOSO
//   Any state -> FALHA on a water-level alarm; FALHA is left only through an
//   operator acknowledge once the alarm has cleared.
//
// Parameters
//   T_PARTIDA  pump-priming duration in cycles            (1..255)
//   T_MIN      minimum irrigation on-time in cycles       (1..255)
//   T_PAUSA    post-irrigation rest time in cycles        (1..255)
//   T_MAX      maximum irrigation time in cycles (T_MIN..255), only
//              meaningful when the macro TEMPO_MAXIMO_EN is defined
//
// Optional feature
//   TEMPO_MAXIMO_EN  when defined, an irrigation phase reaching T_MAX cycles
//                    is cut short into PAUSA and excesso pulses for the first
//                    PAUSA cycle. When undefined there is no time limit and
//                    excesso is constantly 0.
//
// Ports
//   clock             sole clock, rising edge
//   reset_n           asynchronous active-low reset
//   gotejamento       drip-irrigation request level
//   aspersao          sprinkler-irrigation request level (wins over drip)
//   alarme            water-level alarm level (overrides everything)
//   reconhecer        operator fault acknowledge
//   bomba             pump
//   valvula_gotejo    drip valve
//   valvula_aspersor  sprinkler valve
//   sirene            siren
//   estado[2:0]       current state code (OCIOSO=0 .. FALHA=5)
//   excesso           one-cycle max-time pulse (TEMPO_MAXIMO_EN only)
// -----------------------------------------------------------------------------
module controle_atuadores #(
    parameter int T_PARTIDA = 8,
    parameter int T_MIN     = 16,
    parameter int T_PAUSA   = 8,
    parameter int T_MAX     = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       gotejamento,
    input  logic       aspersao,
    input  logic       alarme,
    input  logic       reconhecer,
    output logic       bomba,
    output logic       valvula_gotejo,
    output logic       valvula_aspersor,
    output logic       sirene,
    output logic [2:0] estado,
    output logic       excesso
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    if (T_PARTIDA < 1 || T_PARTIDA > 255) begin : g_t_partida_invalido
        $error("controle_atuadores: T_PARTIDA must be in 1..255");
    end
    if (T_MIN < 1 || T_MIN > 255) begin : g_t_min_invalido
        $error("controle_atuadores: T_MIN must be in 1..255");
    end
    if (T_PAUSA < 1 || T_PAUSA > 255) begin : g_t_pausa_invalido
        $error("controle_atuadores: T_PAUSA must be in 1..255");
    end
    if (T_MAX < T_MIN || T_MAX > 255) begin : g_t_max_invalido
        $error("controle_atuadores: T_MAX must be in T_MIN..255");
    end

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        PARTIDA  = 3'd1,
        GOTEJO   = 3'd2,
        ASPERSAO = 3'd3,
        PAUSA    = 3'd4,
        FALHA    = 3'd5
    } estado_t;

    typedef enum logic {
        MODO_GOTEJO   = 1'b0,
        MODO_ASPERSAO = 1'b1
    } modo_t;

    // Last counter value of each timed phase: the counter starts at 0 on the
    // first cycle of a state, so a phase of N cycles ends when it reads N-1.
    localparam logic [7:0] ULTIMO_PARTIDA = 8'(T_PARTIDA - 1);
    localparam logic [7:0] ULTIMO_MIN     = 8'(T_MIN - 1);
    localparam logic [7:0] ULTIMO_PAUSA   = 8'(T_PAUSA - 1);
`ifdef TEMPO_MAXIMO_EN
    localparam logic [7:0] ULTIMO_MAX     = 8'(T_MAX - 1);
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    estado_t    estado_q;
    estado_t    estado_d;
    modo_t      modo_q;
    modo_t      modo_d;
    logic [7:0] contador;
    logic       excesso_d;
    logic       pedido;

    // The request that keeps the current irrigation phase alive is the one for
    // the mode latched when leaving OCIOSO; the other request is ignored until
    // the cycle has gone back through PAUSA and OCIOSO.
    assign pedido = (modo_q == MODO_ASPERSAO) ? aspersao : gotejamento;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned; otherwise synthesis would infer a latch.
        estado_d  = estado_q;
        modo_d    = modo_q;
        excesso_d = 1'b0;

        if (alarme) begin
            // The alarm overrides every other transition, including staying
            // in FALHA while it is still active.
            estado_d = FALHA;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (aspersao) begin
                        estado_d = PARTIDA;
                        modo_d   = MODO_ASPERSAO;
                    end else if (gotejamento) begin
                        estado_d = PARTIDA;
                        modo_d   = MODO_GOTEJO;
                    end
                end

                PARTIDA: begin
                    // Requests are not looked at while priming.
                    if (contador == ULTIMO_PARTIDA) begin
                        estado_d = (modo_q == MODO_ASPERSAO) ? ASPERSAO : GOTEJO;
                    end
                end

                GOTEJO, ASPERSAO: begin
`ifdef TEMPO_MAXIMO_EN
                    if (contador == ULTIMO_MAX) begin
                        estado_d  = PAUSA;
                        excesso_d = 1'b1;
                    end else
`endif
                    if (contador >= ULTIMO_MIN && !pedido) begin
                        estado_d = PAUSA;
                    end
                end

                PAUSA: begin
                    if (contador == ULTIMO_PAUSA) begin
                        estado_d = OCIOSO;
                    end
                end

                FALHA: begin
                    // alarme is known to be 0 on this path.
                    if (reconhecer) begin
                        estado_d = PAUSA;
                    end
                end

                default: begin
                    // Unused codes 6..7 are treated as a fault.
                    estado_d = FALHA;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers: state, cycle counter, latched mode and Moore outputs.
    // Outputs are decoded from the next state so they change on the same edge
    // as estado and come straight from flops.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q         <= OCIOSO;
            modo_q           <= MODO_GOTEJO;
            contador         <= 8'd0;
            bomba            <= 1'b0;
            valvula_gotejo   <= 1'b0;
            valvula_aspersor <= 1'b0;
            sirene           <= 1'b0;
            excesso          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before this edge, independent of statement order.
            estado_q <= estado_d;
            modo_q   <= modo_d;

            if (estado_d != estado_q) begin
                contador <= 8'd0;
            end else if (contador != 8'hFF) begin
                contador <= contador + 8'd1;
            end

            bomba            <= (estado_d == PARTIDA) || (estado_d == GOTEJO) ||
                                (estado_d == ASPERSAO);
            valvula_gotejo   <= (estado_d == GOTEJO);
            valvula_aspersor <= (estado_d == ASPERSAO);
            sirene           <= (estado_d == FALHA);
            excesso          <= excesso_d;
        end
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_controle_atuadores.sv
// -----------------------------------------------------------------------------
// tb_controle_atuadores
//
// Self-checking bench for controle_atuadores with default parameters.
// A table of {inputs, cycle count, expected state} rows drives the main
// sequences; expected outputs are pushed to a scoreboard queue as each cycle
// is driven and popped/compared one time unit after the rising edge.
// Hand-written sequences cover reset behaviour and the long-irrigation case
// (with and without TEMPO_MAXIMO_EN).
// -----------------------------------------------------------------------------
module tb_controle_atuadores;

    localparam logic [2:0] S_OCIOSO   = 3'd0;
    localparam logic [2:0] S_PARTIDA  = 3'd1;
    localparam logic [2:0] S_GOTEJO   = 3'd2;
    localparam logic [2:0] S_ASPERSAO = 3'd3;
    localparam logic [2:0] S_PAUSA    = 3'd4;
    localparam logic [2:0] S_FALHA    = 3'd5;

    logic       clock;
    logic       reset_n;
    logic       gotejamento;
    logic       aspersao;
    logic       alarme;
    logic       reconhecer;
    logic       bomba;
    logic       valvula_gotejo;
    logic       valvula_aspersor;
    logic       sirene;
    logic [2:0] estado;
    logic       excesso;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       got;
        logic       asp;
        logic       alm;
        logic       rec;
        int         n;
        logic [2:0] est;
    } vec_t;

    typedef struct {
        logic [7:0] saidas;
        string      nome;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    controle_atuadores dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .gotejamento      (gotejamento),
        .aspersao         (aspersao),
        .alarme           (alarme),
        .reconhecer       (reconhecer),
        .bomba            (bomba),
        .valvula_gotejo   (valvula_gotejo),
        .valvula_aspersor (valvula_aspersor),
        .sirene           (sirene),
        .estado           (estado),
        .excesso          (excesso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view {estado, bomba, vg, va, sirene, excesso}.
    function automatic logic [7:0] saidas_dut();
        return {estado, bomba, valvula_gotejo, valvula_aspersor, sirene, excesso};
    endfunction

    // Expected Moore outputs for a state code.
    function automatic logic [7:0] esperado(input logic [2:0] est, input logic exc);
        logic b, vg, va, s;
        b  = 1'b0;
        vg = 1'b0;
        va = 1'b0;
        s  = 1'b0;
        case (est)
            S_PARTIDA:  b = 1'b1;
            S_GOTEJO:   begin b = 1'b1; vg = 1'b1; end
            S_ASPERSAO: begin b = 1'b1; va = 1'b1; end
            S_FALHA:    s = 1'b1;
            default:    ;
        endcase
        return {est, b, vg, va, s, exc};
    endfunction

    task automatic check(input string nome, input logic [7:0] atual, input logic [7:0] req);
        checks++;
        if (atual !== req) begin
            failures++;
            $display("FAIL %s: got est=%0d b/vg/va/s/exc=%b required est=%0d b/vg/va/s/exc=%b",
                     nome, atual[7:5], atual[4:0], req[7:5], req[4:0]);
        end
    endtask

    // One clock cycle: drive inputs, push the expectation, clock, compare.
    task automatic step(input logic got, input logic asp, input logic alm, input logic rec,
                        input logic [2:0] est, input logic exc, input string nome);
        exp_t e;
        gotejamento = got;
        aspersao    = asp;
        alarme      = alm;
        reconhecer  = rec;
        e.saidas = esperado(est, exc);
        e.nome   = nome;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check(e.nome, saidas_dut(), e.saidas);
    endtask

    task automatic pulso_reset();
        reset_n = 1'b0;
        #1;
        check("reset_async", saidas_dut(), esperado(S_OCIOSO, 1'b0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        gotejamento = 1'b0;
        aspersao    = 1'b0;
        alarme      = 1'b0;
        reconhecer  = 1'b0;

        // got asp alm rec  n  expected state
        // Drip cycle, request dropped at irrigation cycle 5.
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  2, S_OCIOSO});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  8, S_PARTIDA});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  5, S_GOTEJO});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 11, S_GOTEJO});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  8, S_PAUSA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  2, S_OCIOSO});
        // Requests ignored in PARTIDA; other mode not served while irrigating.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, S_PARTIDA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  7, S_PARTIDA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16, S_GOTEJO});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  8, S_PAUSA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  1, S_OCIOSO});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  8, S_PARTIDA});
        // Alarm during ASPERSAO, acknowledge ignored while alarm active.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  3, S_ASPERSAO});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  1, S_FALHA});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1,  2, S_FALHA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  3, S_FALHA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  1, S_PAUSA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  7, S_PAUSA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,  1, S_OCIOSO});
        // Both requests: sprinkler wins; held past T_MIN then released.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  8, S_PARTIDA});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 20, S_ASPERSAO});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  8, S_PAUSA});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, S_OCIOSO});
        // Alarm during PARTIDA and from OCIOSO.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, S_PARTIDA});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0,  1, S_FALHA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  1, S_PAUSA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  7, S_PAUSA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, S_OCIOSO});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  2, S_FALHA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  1, S_PAUSA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  7, S_PAUSA});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, S_OCIOSO});

        // Reset state before any clock edge.
        #1;
        check("reset_inicial", saidas_dut(), esperado(S_OCIOSO, 1'b0));
        @(posedge clock);
        #1;
        check("reset_mantido", saidas_dut(), esperado(S_OCIOSO, 1'b0));
        reset_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            for (int c = 0; c < vecs[r].n; c++) begin
                step(vecs[r].got, vecs[r].asp, vecs[r].alm, vecs[r].rec,
                     vecs[r].est, 1'b0, $sformatf("linha%0d_ciclo%0d", r, c));
            end
        end

        // Reset asserted between edges in the middle of GOTEJO.
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b0, 1'b0, S_PARTIDA, 1'b0, "pre_reset_partida");
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 1'b0, S_GOTEJO, 1'b0, "pre_reset_gotejo");
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_meio_gotejo", saidas_dut(), esperado(S_OCIOSO, 1'b0));
        @(posedge clock);
        #1;
        check("reset_segura_borda", saidas_dut(), esperado(S_OCIOSO, 1'b0));
        // First edge with reset_n high must already take the transition.
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, S_PARTIDA, 1'b0, "primeira_borda_pos_reset");
        for (int c = 0; c < 7; c++) step(1'b1, 1'b0, 1'b0, 1'b0, S_PARTIDA, 1'b0, "pos_reset_partida");
        step(1'b1, 1'b0, 1'b0, 1'b0, S_GOTEJO, 1'b0, "pos_reset_gotejo");
        pulso_reset();

        // Long sprinkler request.
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b0, 1'b0, S_PARTIDA, 1'b0, "longo_partida");
`ifdef TEMPO_MAXIMO_EN
        for (int c = 0; c < 64; c++) step(1'b0, 1'b1, 1'b0, 1'b0, S_ASPERSAO, 1'b0, "longo_aspersao");
        step(1'b0, 1'b1, 1'b0, 1'b0, S_PAUSA, 1'b1, "excesso_pulso");
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 1'b0, 1'b0, S_PAUSA, 1'b0, "excesso_pausa");
        step(1'b0, 1'b1, 1'b0, 1'b0, S_OCIOSO, 1'b0, "excesso_ocioso");
        step(1'b0, 1'b1, 1'b0, 1'b0, S_PARTIDA, 1'b0, "excesso_reinicio");
`else
        for (int c = 0; c < 300; c++) step(1'b0, 1'b1, 1'b0, 1'b0, S_ASPERSAO, 1'b0, "longo_aspersao");
        step(1'b0, 1'b0, 1'b0, 1'b0, S_PAUSA, 1'b0, "longo_fim_pausa");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
